// File: rtl/genius_pkg.sv
// genius_pkg -- shared definitions for the Genius (Simon-style) sequence game.
//   state_t     : controller state encoding
//   SYM_W       : width of one symbol nibble
//   MAX_ROUND   : last round index (16 rounds total)
//   LFSR_SEED   : reset value of the symbol LFSR
//   sym_onehot  : maps two random bits to a one-hot 4-bit symbol
package genius_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHOW_ON,
        ST_SHOW_OFF,
        ST_WAIT_IN,
        ST_WIN,
        ST_LOSE
    } state_t;

    localparam int          SYM_W     = 4;
    localparam logic [3:0]  MAX_ROUND = 4'd15;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic logic [SYM_W-1:0] sym_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/genius_lfsr.sv
// genius_lfsr -- free-running 16-bit Fibonacci LFSR (taps 16,14,13,11).
//   CLK  : clock, rising edge
//   R    : synchronous active-high reset, loads LFSR_SEED
//   lfsr : current LFSR state
module genius_lfsr
    import genius_pkg::*;
(
    input  logic        CLK,
    input  logic        R,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb;

    // Right-shifting form: tap 16 is bit 0, taps 14/13/11 are bits 2/3/5.
    always_comb begin
        fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d = {fb, lfsr_q[15:1]};
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/genius_seq_ctrl.sv
// genius_seq_ctrl -- game controller: grows a random symbol sequence, plays it
// back on the LEDs and checks the player's button presses against it.
//   CLK, R    : clock and synchronous active-high reset
//   start     : starts a new game from IDLE, WIN or LOSE
//   btn       : one-cycle button press, 0 = none
//   reg_q     : stored sequence from the external sequence register
//   reg_data  : write data to the sequence register (0 outside ADD)
//   reg_E     : one-cycle write enable to the sequence register
//   leds      : symbol display
//   round     : current round index (sequence length minus 1)
//   busy      : high while a game is in progress
//   win, lose : game outcome flags
module genius_seq_ctrl
    import genius_pkg::*;
#(
    parameter int N    = 64,
    parameter int TICK = 25000000
) (
    input  logic         CLK,
    input  logic         R,
    input  logic         start,
    input  logic [3:0]   btn,
    input  logic [N-1:0] reg_q,
    output logic [N-1:0] reg_data,
    output logic         reg_E,
    output logic [3:0]   leds,
    output logic [3:0]   round,
    output logic         busy,
    output logic         win,
    output logic         lose
);

    localparam int            TW        = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK - 1);

    state_t         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [3:0]     idx_q, idx_d;
    logic [TW-1:0]  tick_q, tick_d;

    logic [15:0]      lfsr_w;
    logic [SYM_W-1:0] sym;
    logic [SYM_W-1:0] cur_nib;
    logic             tick_done;
    logic             unused_lfsr_hi;

    genius_lfsr u_lfsr (
        .CLK  (CLK),
        .R    (R),
        .lfsr (lfsr_w)
    );

    // Only the two low LFSR bits pick the symbol.
    assign unused_lfsr_hi = ^lfsr_w[15:2];

    always_comb begin
        sym       = sym_onehot(lfsr_w[1:0]);
        cur_nib   = reg_q[{idx_q, 2'b00} +: SYM_W];
        tick_done = (tick_q == TICK_LAST);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (R) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            idx_q   <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            idx_q   <= idx_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        idx_d   = idx_q;
        tick_d  = tick_q;
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d = ST_ADD;
                    round_d = '0;
                    idx_d   = '0;
                    tick_d  = '0;
                end
            end
            ST_ADD: begin
                state_d = ST_SHOW_ON;
                idx_d   = '0;
                tick_d  = '0;
            end
            ST_SHOW_ON: begin
                if (tick_done) begin
                    tick_d  = '0;
                    state_d = ST_SHOW_OFF;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_SHOW_OFF: begin
                if (tick_done) begin
                    tick_d = '0;
                    if (idx_q == round_q) begin
                        state_d = ST_WAIT_IN;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_SHOW_ON;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            ST_WAIT_IN: begin
                if (btn != '0) begin
                    // Any press other than the exact expected one-hot nibble,
                    // including multi-hot, ends the game.
                    if (btn == cur_nib) begin
                        if (idx_q == round_q) begin
                            if (round_q == MAX_ROUND) begin
                                state_d = ST_WIN;
                            end else begin
                                round_d = round_q + 1'b1;
                                state_d = ST_ADD;
                            end
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_LOSE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        reg_data = '0;
        reg_E    = 1'b0;
        leds     = '0;
        win      = 1'b0;
        lose     = 1'b0;
        busy     = 1'b1;
        round    = round_q;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_ADD: begin
                reg_E = 1'b1;
                if (round_q == '0) begin
                    reg_data = {{(N-SYM_W){1'b0}}, sym};
                end else begin
                    reg_data = reg_q;
                    reg_data[{round_q, 2'b00} +: SYM_W] = sym;
                end
            end
            ST_SHOW_ON: begin
                leds = cur_nib;
            end
            ST_WIN: begin
                busy = 1'b0;
                win  = 1'b1;
                leds = '1;
            end
            ST_LOSE: begin
                busy = 1'b0;
                lose = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_genius_seq_ctrl.sv
// tb_genius_seq_ctrl -- directed bench for genius_seq_ctrl with TICK=2.
// Models the external sequence register and an independent LFSR reference.
module tb_genius_seq_ctrl;

    logic        clk = 1'b0;
    logic        R = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  btn = '0;
    logic [63:0] reg_q = '0;
    logic [63:0] reg_data;
    logic        reg_E;
    logic [3:0]  leds;
    logic [3:0]  round;
    logic        busy;
    logic        win;
    logic        lose;

    int total = 0;
    int bad = 0;
    int epulses = 0;
    int ebase;
    logic [15:0] m_lfsr;
    logic [3:0]  seq [16];

    genius_seq_ctrl #(.N(64), .TICK(2)) dut (
        .CLK      (clk),
        .R        (R),
        .start    (start),
        .btn      (btn),
        .reg_q    (reg_q),
        .reg_data (reg_data),
        .reg_E    (reg_E),
        .leds     (leds),
        .round    (round),
        .busy     (busy),
        .win      (win),
        .lose     (lose)
    );

    always #5 clk = ~clk;

    // External sequence register, LFSR reference and write-pulse counter.
    always @(posedge clk) begin
        if (reg_E === 1'b1) begin
            reg_q   <= reg_data;
            epulses <= epulses + 1;
        end
        if (R) m_lfsr <= 16'hACE1;
        else   m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [75:0] vec(input logic [63:0] d, input logic e,
                                        input logic [3:0] l, input logic [3:0] r,
                                        input logic b, input logic w, input logic lo);
        return {d, e, l, r, b, w, lo};
    endfunction

    function automatic logic [75:0] obs();
        return {reg_data, reg_E, leds, round, busy, win, lose};
    endfunction

    function automatic logic [63:0] build(input int r);
        logic [63:0] d = '0;
        for (int k = 0; k <= r; k++) d = d | (64'(seq[k]) << (4 * k));
        return d;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] s);
        case (s)
            2'd0: return 4'b0001;
            2'd1: return 4'b0010;
            2'd2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [75:0] o, input logic [75:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Entered at a negedge in ADD; leaves at a negedge in WAIT_IN.
    task automatic add_and_show(input int r, input bit inject);
        seq[r] = onehot(m_lfsr[1:0]);
        chk("add", obs(), vec(build(r), 1'b1, 4'h0, 4'(r), 1'b1, 1'b0, 1'b0));
        tick();
        for (int i = 0; i <= r; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (inject && i == 0 && c == 0) begin
                    btn   = 4'b1111;
                    start = 1'b1;
                end
                chk("show_on", obs(), vec('0, 1'b0, seq[i], 4'(r), 1'b1, 1'b0, 1'b0));
                tick();
                btn   = '0;
                start = 1'b0;
            end
            for (int c = 0; c < 2; c++) begin
                chk("show_off", obs(), vec('0, 1'b0, 4'h0, 4'(r), 1'b1, 1'b0, 1'b0));
                tick();
            end
        end
        chk("wait_in", obs(), vec('0, 1'b0, 4'h0, 4'(r), 1'b1, 1'b0, 1'b0));
    endtask

    // Presses the whole sequence correctly; leaves at the negedge after the last press.
    task automatic press_all(input int r);
        for (int i = 0; i <= r; i++) begin
            btn = seq[i];
            tick();
            btn = '0;
            if (i < r) begin
                chk("wait_step", obs(), vec('0, 1'b0, 4'h0, 4'(r), 1'b1, 1'b0, 1'b0));
                if (i == 0) begin
                    tick();
                    chk("wait_hold", obs(), vec('0, 1'b0, 4'h0, 4'(r), 1'b1, 1'b0, 1'b0));
                end
            end
        end
    endtask

    initial begin
        // Power-up reset
        repeat (3) tick();
        chk("reset", obs(), vec('0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
        chk("lfsr_seed", 76'(dut.lfsr_w), 76'(16'hACE1));
        R = 1'b0;
        tick();
        chk("idle", obs(), vec('0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));

        // Game A: reset held 2 cycles during SHOW_ON, with start/btn asserted
        start = 1'b1;
        tick();
        start = 1'b0;
        seq[0] = onehot(m_lfsr[1:0]);
        chk("add_a", obs(), vec(build(0), 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0));
        tick();
        chk("show_on_a", obs(), vec('0, 1'b0, seq[0], 4'h0, 1'b1, 1'b0, 1'b0));
        R = 1'b1;
        start = 1'b1;
        btn = 4'b0001;
        tick();
        chk("reset_mid1", obs(), vec('0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
        chk("lfsr_mid1", 76'(dut.lfsr_w), 76'(16'hACE1));
        tick();
        chk("reset_mid2", obs(), vec('0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));
        chk("lfsr_mid2", 76'(dut.lfsr_w), 76'(16'hACE1));
        R = 1'b0;
        start = 1'b0;
        btn = '0;
        tick();
        chk("idle_a", obs(), vec('0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0));

        // Game B: two rounds, ignored inputs during playback, then a multi-hot loss
        start = 1'b1;
        tick();
        start = 1'b0;
        add_and_show(0, 1'b0);
        press_all(0);
        add_and_show(1, 1'b1);
        btn = seq[0];
        tick();
        btn = '0;
        chk("wait_idx1", obs(), vec('0, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0));
        btn = 4'b0011;
        tick();
        btn = '0;
        chk("lose", obs(), vec('0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b1));
        btn = seq[1];
        tick();
        btn = '0;
        chk("lose_hold", obs(), vec('0, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 1'b1));

        // Game C: restart from LOSE and play all 16 rounds to a win
        ebase = epulses;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 16; r++) begin
            add_and_show(r, 1'b0);
            press_all(r);
        end
        chk("win", obs(), vec('0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0));
        chk("reg_e_count", 76'(epulses - ebase), 76'(16));
        btn = seq[0];
        tick();
        btn = '0;
        chk("win_hold", obs(), vec('0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
